// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types for the AddRoundKey stage.
// ARK_KEY_PARITY_EN adds the per-beat key_err flag to ark_beat_t.
package aes_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef logic [127:0] state_t;
    typedef logic [3:0]   round_t;

    typedef struct packed {
        state_t data;
        round_t round;
        logic   mix;
        logic   last;
`ifdef ARK_KEY_PARITY_EN
        logic   key_err;
`endif
    } ark_beat_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice (main + skid) for full throughput.
// up_ready is a registered flag (!skid full), never a path from dn_ready.
module skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);

    logic              vld_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] main_p1;
    logic [DATA_W-1:0] skid_p1;
    logic              up_xfer;
    logic              main_free;

    assign up_ready  = !skid_vld_p1;
    assign up_xfer   = up_valid && up_ready;
    assign main_free = !vld_p1 || dn_ready;

    // ---- p0 -> p1: main/skid registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (main_free) begin
            // A parked skid beat always goes ahead of the input to keep order.
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= up_xfer;
                if (up_xfer) begin
                    main_p1 <= up_data;
                end
            end
        end else if (up_xfer) begin
            skid_p1     <= up_data;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign dn_valid = vld_p1;
    assign dn_data  = main_p1;

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AES inverse-cipher AddRoundKey: state ^ key, round tagging, skid output.
// Optional build macro ARK_KEY_PARITY_EN adds i_key_par / o_key_err.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_128
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    input  logic         i_first,
`ifdef ARK_KEY_PARITY_EN
    input  logic [15:0]  i_key_par,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic [3:0]   o_round,
    output logic         o_mix,
`ifdef ARK_KEY_PARITY_EN
    output logic         o_key_err,
`endif
    output logic         o_last
);

    localparam round_t ROUND_NR  = round_t'(NR);
    localparam round_t ROUND_NR1 = round_t'(NR - 1);

    round_t    next_round;
    round_t    round_p0;
    ark_beat_t beat_p0;
    ark_beat_t beat_p1;
    logic      in_xfer;

    // Rounds strictly between the initial and final ones go through inv_mix_columns.
    function automatic logic needs_mix(input round_t r);
        return (r >= round_t'(1)) && (r <= ROUND_NR1);
    endfunction

`ifdef ARK_KEY_PARITY_EN
    function automatic logic key_par_err(input state_t key, input logic [15:0] par);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 16; b++) begin
            err = err | ((^key[127-8*b -: 8]) ^ par[15-b]);
        end
        return err;
    endfunction
`endif

    assign in_xfer  = i_valid && o_ready;
    assign round_p0 = i_first ? ROUND_NR : next_round;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            next_round <= ROUND_NR;
        end else if (in_xfer) begin
            if (i_first) begin
                next_round <= ROUND_NR1;
            end else if (next_round == round_t'(0)) begin
                next_round <= ROUND_NR;
            end else begin
                next_round <= next_round - round_t'(1);
            end
        end
    end

    // ---- p0: combinational beat assembly ----
    always_comb begin
        beat_p0         = '0;
        beat_p0.data    = i_data ^ i_key;
        beat_p0.round   = round_p0;
        beat_p0.mix     = needs_mix(round_p0);
        beat_p0.last    = (round_p0 == round_t'(0));
`ifdef ARK_KEY_PARITY_EN
        beat_p0.key_err = key_par_err(i_key, i_key_par);
`endif
    end

    // ---- p1: registered output slice ----
    skid_buffer #(
        .DATA_W($bits(ark_beat_t))
    ) u_skid (
        .clk      (i_clk),
        .rst      (i_rst),
        .up_valid (i_valid),
        .up_ready (o_ready),
        .up_data  (beat_p0),
        .dn_valid (o_valid),
        .dn_ready (i_ready),
        .dn_data  (beat_p1)
    );

    assign o_data    = beat_p1.data;
    assign o_round   = beat_p1.round;
    assign o_mix     = beat_p1.mix;
    assign o_last    = beat_p1.last;
`ifdef ARK_KEY_PARITY_EN
    assign o_key_err = beat_p1.key_err;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: directed vectors, queue-based output monitor.
module tb_add_round_key_stage;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic [127:0] i_key;
    logic         i_first;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic [3:0]   o_round;
    logic         o_mix;
    logic         o_last;
`ifdef ARK_KEY_PARITY_EN
    logic [15:0]  i_key_par;
    logic         o_key_err;
`endif

    typedef struct {
        logic [127:0] d;
        logic [3:0]   r;
        logic         m;
        logic         l;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    add_round_key_stage #(.NR(10)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_key     (i_key),
        .i_first   (i_first),
`ifdef ARK_KEY_PARITY_EN
        .i_key_par (i_key_par),
        .o_key_err (o_key_err),
`endif
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_round   (o_round),
        .o_mix     (o_mix),
        .o_last    (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] good_par(input logic [127:0] k);
        logic [15:0] p;
        for (int b = 0; b < 16; b++) p[15-b] = ^k[127-8*b -: 8];
        return p;
    endfunction

    // Monitor: every output transfer pops one expected beat.
    always @(negedge clk) begin
        if (!rst && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %h round %0d expected none", o_data, o_round);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", o_data, e.d);
                chk("out_round", 128'(o_round), 128'(e.r));
                chk("out_mix", 128'(o_mix), 128'(e.m));
                chk("out_last", 128'(o_last), 128'(e.l));
`ifdef ARK_KEY_PARITY_EN
                chk("out_key_err", 128'(o_key_err), 128'(e.e));
`endif
            end
        end
    end

    // Offer one beat and wait (bounded) for it to be accepted; push its expectation.
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic f,
                        input logic [127:0] xd, input logic [3:0] xr, input logic flip);
        logic acc;
        int   n;
        exp_t e;
        i_valid = 1'b1;
        i_data  = d;
        i_key   = k;
        i_first = f;
`ifdef ARK_KEY_PARITY_EN
        i_key_par = good_par(k) ^ {flip, 15'b0};
`endif
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept of round %0d", xr);
        end else begin
            e.d = xd;
            e.r = xr;
            e.m = (xr >= 4'd1 && xr <= 4'd9);
            e.l = (xr == 4'd0);
            e.e = flip;
            sb.push_back(e);
        end
        i_valid = 1'b0;
    endtask

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [127:0] d;
        logic [127:0] a_exp;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_key   = '0;
        i_first = 1'b0;
        i_ready = 1'b1;
`ifdef ARK_KEY_PARITY_EN
        i_key_par = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_ready", 128'(o_ready), 128'(1));
        chk("rst_data", o_data, 128'h0);
        chk("rst_round", 128'(o_round), 128'(0));
        chk("rst_mix", 128'(o_mix), 128'(0));
        chk("rst_last", 128'(o_last), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FIPS-197 C.1 round-10 AddRoundKey, one-cycle latency
        send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1,
             128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd10, 1'b0);
        chk("fips_latency_valid", 128'(o_valid), 128'(1));
        chk("fips_latency_data", o_data, 128'h7ad5fda789ef4e272bca100b3d9ff59f);

        // Full 11-round stream, then auto restart
        for (int i = 0; i < 11; i++) begin
            d = {16{8'(i * 17)}};
            send(d, KEY_A, (i == 0), d ^ KEY_A, 4'(10 - i), 1'b0);
        end
        send(128'hffeeddccbbaa99887766554433221100, KEY_A, 1'b0,
             128'hffefdfcfbfaf9f8f7f6f5f4f3f2f1f0f, 4'd10, 1'b0);

        // Mid-sequence restart after the round-4 beat
        for (int i = 0; i < 7; i++) begin
            send(128'h0, KEY_A, (i == 0), KEY_A, 4'(10 - i), 1'b0);
        end
        send(128'h1, 128'h2, 1'b1, 128'h3, 4'd10, 1'b0);
        send(128'h4, 128'h1, 1'b0, 128'h5, 4'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: A held, B in skid, C refused until release
        i_ready = 1'b0;
        a_exp = 128'ha0a0 ^ KEY_A;
        send(128'ha0a0, KEY_A, 1'b1, a_exp, 4'd10, 1'b0);
        send(128'hb0b0, KEY_A, 1'b0, 128'hb0b0 ^ KEY_A, 4'd9, 1'b0);
        chk("bp_ready_after_b", 128'(o_ready), 128'(0));
        chk("bp_hold_data0", o_data, a_exp);
        i_valid = 1'b1;
        i_data  = 128'hc0c0;
        i_key   = KEY_A;
        i_first = 1'b0;
`ifdef ARK_KEY_PARITY_EN
        i_key_par = good_par(KEY_A);
`endif
        @(posedge clk);
        #1;
        chk("bp_c_refused", 128'(o_ready), 128'(0));
        chk("bp_hold_valid", 128'(o_valid), 128'(1));
        chk("bp_hold_data1", o_data, a_exp);
        chk("bp_hold_round", 128'(o_round), 128'(10));
        chk("bp_queue_two", 128'(sb.size()), 128'(2));
        i_ready = 1'b1;
        send(128'hc0c0, KEY_A, 1'b0, 128'hc0c0 ^ KEY_A, 4'd8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 128'(sb.size()), 128'(0));

        // Async reset with main and skid full
        i_ready = 1'b0;
        send(128'h11, 128'h22, 1'b1, 128'h33, 4'd10, 1'b0);
        send(128'h44, 128'h22, 1'b0, 128'h66, 4'd9, 1'b0);
        chk("pre_rst_valid", 128'(o_valid), 128'(1));
        chk("pre_rst_ready", 128'(o_ready), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(o_valid), 128'(0));
        chk("async_rst_data", o_data, 128'h0);
        chk("async_rst_ready", 128'(o_ready), 128'(1));
        sb.delete();
        i_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(128'h5a, 128'ha5, 1'b0, 128'hff, 4'd10, 1'b0);

`ifdef ARK_KEY_PARITY_EN
        send(128'h0, KEY_A, 1'b0, KEY_A, 4'd9, 1'b1);
        send(128'h0, KEY_A, 1'b0, KEY_A, 4'd8, 1'b0);
`endif

        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("final_queue_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
